// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Defining UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} uart_tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with extra-bit pointers so full and empty are distinguishable.
// Read data is the combinational head entry; pushes when full and pops when empty are ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 LSB first, back-to-back frames without idle gap.
// Build with UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 862,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid_i,
  input  logic [UART_DATA_W-1:0]        wr_data_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  // state  | meaning
  // IDLE   | line high, waiting for a byte in the FIFO
  // START  | start bit (low)
  // DATA   | eight data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit (high), chains straight into START if more data

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   pop;
  logic                   bit_end;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid_i),
    .push_data (wr_data_i),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  assign bit_end    = (cnt_q == CNT_LAST);
  assign wr_ready_o = !fifo_full;
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign tx_o       = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(fifo_head);
`endif
          state_d = START;
          tx_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // next byte already waiting: start bit begins on this edge
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(fifo_head);
`endif
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: fast-baud instance for timing/FIFO scenarios, slow-baud instance for loopback.
// Behavioural line decoders rebuild bytes from tx and are compared with the queue of accepted bytes.
module tb_uart_tx_fifo;

  localparam int CPB_A = 4;
  localparam int CPB_B = 862;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid_a = 1'b0, wr_valid_b = 1'b0;
  logic [7:0] wr_data_a = 8'h00, wr_data_b = 8'h00;
  logic       wr_ready_a, wr_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [4:0] level_a, level_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid_a), .wr_data_i(wr_data_a),
    .wr_ready_o(wr_ready_a), .tx_o(tx_a), .busy_o(busy_a), .fifo_level_o(level_a));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid_b), .wr_data_i(wr_data_b),
    .wr_ready_o(wr_ready_b), .tx_o(tx_b), .busy_o(busy_b), .fifo_level_o(level_b));

  // reference: expected line level for frame bit j of byte b
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  logic [7:0] exp_q_a[$];
  logic [7:0] rx_q_a[$];
  int         start_q_a[$];
  int         bad_a = 0;
  bit         mon_en_a = 1'b1;
  logic [7:0] rx_q_b[$];
  int         bad_b = 0;

  // mid-bit sampling decoder on the fast line
  int         m_start_a;
  bit         m_ok_a;
  logic [7:0] m_byte_a;
  always begin : mon_a
    @(negedge clk);
    if (mon_en_a && tx_a === 1'b0) begin
      m_start_a = cyc;
      repeat (CPB_A/2) @(negedge clk);
      m_ok_a = (tx_a === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB_A) @(negedge clk);
        m_byte_a[i] = tx_a;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB_A) @(negedge clk);
      if (tx_a !== ^m_byte_a) m_ok_a = 1'b0;
`endif
      repeat (CPB_A) @(negedge clk);
      if (tx_a !== 1'b1) m_ok_a = 1'b0;
      if (!m_ok_a) bad_a++;
      rx_q_a.push_back(m_byte_a);
      start_q_a.push_back(m_start_a);
    end
  end

  // loopback receiver on the slow line
  bit         m_ok_b;
  logic [7:0] m_byte_b;
  always begin : mon_b
    @(negedge clk);
    if (rst_n && tx_b === 1'b0) begin
      repeat (CPB_B/2) @(negedge clk);
      m_ok_b = (tx_b === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB_B) @(negedge clk);
        m_byte_b[i] = tx_b;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB_B) @(negedge clk);
      if (tx_b !== ^m_byte_b) m_ok_b = 1'b0;
`endif
      repeat (CPB_B) @(negedge clk);
      if (tx_b !== 1'b1) m_ok_b = 1'b0;
      if (!m_ok_b) bad_b++;
      rx_q_b.push_back(m_byte_b);
    end
  end

  // stimulus: call at a negedge; returns at the negedge after the accepting edge
  task automatic push_a(input logic [7:0] b, input bit hold, output int acc);
    int n = 0;
    wr_valid_a = 1'b1;
    wr_data_a  = b;
    while (!wr_ready_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL push_a_timeout ready=%b required=1", wr_ready_a);
    end
    @(negedge clk);
    acc = cyc;
    exp_q_a.push_back(b);
    if (!hold) wr_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while ((busy_a || n < 2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB_A) @(negedge clk);
    if (busy_a) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_a_timeout busy=%b required=0", busy_a);
    end
  endtask

  task automatic clear_a();
    exp_q_a.delete();
    rx_q_a.delete();
    start_q_a.delete();
    bad_a = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (level_a !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_a); end
    checks++; if (wr_ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_ready_a); end
    checks++; if (tx_b !== 1'b1) begin failures++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0", tx_a, busy_a);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] vals[2];
    int n;
    vals[0] = 8'h41;
    vals[1] = 8'($urandom_range(0, 255));
    for (int v = 0; v < 2; v++) begin
      clear_a();
      push_a(vals[v], 1'b0, n);
      checks++; if (tx_a !== 1'b1 || level_a !== 5'd1) begin
        failures++; $display("FAIL frame_pre_start tx=%b level=%0d exp tx=1 level=1", tx_a, level_a);
      end
      for (int k = 0; k < FB*CPB_A; k++) begin
        @(negedge clk);
        checks++; if (tx_a !== frame_bit(vals[v], k / CPB_A) || busy_a !== 1'b1) begin
          failures++;
          $display("FAIL frame_bit byte=%h cycle=%0d tx=%b busy=%b exp tx=%b busy=1",
                   vals[v], k, tx_a, busy_a, frame_bit(vals[v], k / CPB_A));
        end
      end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
        failures++; $display("FAIL frame_end busy=%b tx=%b exp busy=0 tx=1", busy_a, tx_a);
      end
      repeat (4) @(negedge clk);
      checks++; if (rx_q_a.size() != 1 || rx_q_a[0] !== vals[v] || bad_a != 0) begin
        failures++; $display("FAIL frame_decode got_n=%0d bad=%0d exp byte=%h", rx_q_a.size(), bad_a, vals[v]);
      end
    end
  endtask

  task automatic test_fill_backpressure();
    int n;
    int w;
    clear_a();
    for (int i = 0; i <= 16; i++) begin
      checks++; if (wr_ready_a !== (level_a != 5'd16)) begin
        failures++; $display("FAIL ready_vs_level ready=%b level=%0d exp ready=%b", wr_ready_a, level_a, level_a != 5'd16);
      end
      push_a(8'(i), 1'b1, n);
    end
    checks++; if (level_a !== 5'd16 || wr_ready_a !== 1'b0) begin
      failures++; $display("FAIL fill_full level=%0d ready=%b exp level=16 ready=0", level_a, wr_ready_a);
    end
    // extra byte held while full: refused on the pop edge, taken on the next
    wr_data_a = 8'hEE;
    w = 0;
    while (!wr_ready_a && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++; if (level_a !== 5'd15) begin
      failures++; $display("FAIL full_pop_refuse level=%0d exp=15", level_a);
    end
    @(negedge clk);
    wr_valid_a = 1'b0;
    exp_q_a.push_back(8'hEE);
    checks++; if (level_a !== 5'd16) begin
      failures++; $display("FAIL full_refill level=%0d exp=16", level_a);
    end
    wait_idle_a(18*FB*CPB_A + 200);
    checks++; if (rx_q_a.size() != exp_q_a.size() || bad_a != 0) begin
      failures++; $display("FAIL fill_count got=%0d bad=%0d exp=%0d", rx_q_a.size(), bad_a, exp_q_a.size());
    end
    for (int i = 0; i < rx_q_a.size() && i < exp_q_a.size(); i++) begin
      checks++; if (rx_q_a[i] !== exp_q_a[i]) begin
        failures++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, rx_q_a[i], exp_q_a[i]);
      end
    end
    for (int i = 1; i < start_q_a.size(); i++) begin
      checks++; if (start_q_a[i] - start_q_a[i-1] != FB*CPB_A) begin
        failures++; $display("FAIL gapless idx=%0d spacing=%0d exp=%0d", i, start_q_a[i] - start_q_a[i-1], FB*CPB_A);
      end
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [7:0] b[4];
    int n_a, n;
    int w = 0;
    logic [4:0] lvl_before;
    clear_a();
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    push_a(b[0], 1'b0, n_a);
    push_a(b[1], 1'b0, n);
    push_a(b[2], 1'b0, n);
    while (cyc < n_a + FB*CPB_A && w < 1000) begin
      @(negedge clk);
      w++;
    end
    wr_valid_a = 1'b1;
    wr_data_a  = b[3];
    lvl_before = level_a;
    @(negedge clk);
    wr_valid_a = 1'b0;
    exp_q_a.push_back(b[3]);
    checks++; if (level_a !== lvl_before || lvl_before !== 5'd2) begin
      failures++; $display("FAIL push_pop_level before=%0d after=%0d exp=2", lvl_before, level_a);
    end
    checks++; if (tx_a !== 1'b0) begin
      failures++; $display("FAIL push_pop_restart tx=%b exp=0", tx_a);
    end
    wait_idle_a(5*FB*CPB_A + 100);
    checks++; if (rx_q_a.size() != 4 || bad_a != 0) begin
      failures++; $display("FAIL push_pop_count got=%0d bad=%0d exp=4", rx_q_a.size(), bad_a);
    end
    for (int i = 0; i < rx_q_a.size() && i < 4; i++) begin
      checks++; if (rx_q_a[i] !== exp_q_a[i]) begin
        failures++; $display("FAIL push_pop_order idx=%0d got=%h exp=%h", i, rx_q_a[i], exp_q_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int w = 0;
    mon_en_a = 1'b0;
    clear_a();
    push_a(8'h5A, 1'b0, n);
    while (cyc < n + 1 + 4*CPB_A + 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++; if (tx_a !== 1'b1) begin
      failures++; $display("FAIL reset_mid_bit3 tx=%b exp=1", tx_a);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1 || level_a !== 5'd0 || busy_a !== 1'b0 || wr_ready_a !== 1'b1) begin
      failures++; $display("FAIL reset_mid_async tx=%b level=%0d busy=%b ready=%b exp 1/0/0/1", tx_a, level_a, busy_a, wr_ready_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
        failures++; $display("FAIL reset_no_resume cycle=%0d tx=%b busy=%b exp tx=1 busy=0", k, tx_a, busy_a);
      end
    end
    clear_a();
    mon_en_a = 1'b1;
  endtask

  task automatic test_random_stream();
    int n;
    clear_a();
    for (int i = 0; i < 24; i++) begin
      push_a(8'($urandom_range(0, 255)), 1'b0, n);
      if ($urandom_range(0, 7) == 0) repeat (FB*CPB_A*3) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle_a(30*FB*CPB_A + 200);
    checks++; if (rx_q_a.size() != exp_q_a.size() || bad_a != 0) begin
      failures++; $display("FAIL random_count got=%0d bad=%0d exp=%0d", rx_q_a.size(), bad_a, exp_q_a.size());
    end
    for (int i = 0; i < rx_q_a.size() && i < exp_q_a.size(); i++) begin
      checks++; if (rx_q_a[i] !== exp_q_a[i]) begin
        failures++; $display("FAIL random_order idx=%0d got=%h exp=%h", i, rx_q_a[i], exp_q_a[i]);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals[2];
    logic       exp_p[2];
    int n;
    int w;
    vals[0] = 8'h03; exp_p[0] = 1'b0;
    vals[1] = 8'h07; exp_p[1] = 1'b1;
    for (int v = 0; v < 2; v++) begin
      clear_a();
      push_a(vals[v], 1'b0, n);
      w = 0;
      while (cyc < n + 1 + 9*CPB_A + 1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      checks++; if (tx_a !== exp_p[v]) begin
        failures++; $display("FAIL parity_bit byte=%h got=%b exp=%b", vals[v], tx_a, exp_p[v]);
      end
      w = 0;
      while (busy_a && w < 200) begin
        @(negedge clk);
        w++;
      end
      checks++; if (cyc - (n + 1) != 11*CPB_A) begin
        failures++; $display("FAIL parity_frame_len got=%0d exp=%0d", cyc - (n + 1), 11*CPB_A);
      end
      repeat (4) @(negedge clk);
    end
  endtask
`endif

  task automatic test_loopback();
    logic [7:0] msg[4];
    int w = 0;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A; msg[3] = 8'hFF;
    rx_q_b.delete();
    bad_b = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wr_valid_b = 1'b1;
      wr_data_b  = msg[i];
      @(negedge clk);
    end
    wr_valid_b = 1'b0;
    while (rx_q_b.size() < 4 && w < 4*FB*CPB_B + 2000) begin
      @(negedge clk);
      w++;
    end
    checks++; if (rx_q_b.size() != 4 || bad_b != 0) begin
      failures++; $display("FAIL loopback_count got=%0d bad=%0d exp=4", rx_q_b.size(), bad_b);
    end
    for (int i = 0; i < rx_q_b.size() && i < 4; i++) begin
      checks++; if (rx_q_b[i] !== msg[i]) begin
        failures++; $display("FAIL loopback_byte idx=%0d got=%h exp=%h", i, rx_q_b[i], msg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_backpressure();
    test_push_pop_same_cycle();
    test_reset_mid_frame();
    test_random_stream();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
